// File: rtl/game_pkg.sv
// Shared types and helpers for the Sudoku board controller: board geometry, FSM states and
// cell/group index functions.
package game_pkg;

   localparam int unsigned CELLS   = 81;
   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned GROUPS  = 27;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StPlay,
      StCheck
   } game_state_e;

   function automatic logic [6:0] cell_idx(input logic [3:0] row, input logic [3:0] col);
      int unsigned r;
      int unsigned c;
      r = 32'(row);
      c = 32'(col);
      return 7'(r * 9 + c);
   endfunction

   // Groups 0..8 are rows, 9..17 columns, 18..26 boxes in row-major order.
   function automatic logic [6:0] group_cell(input logic [4:0] g, input logic [3:0] k);
      int unsigned gi;
      int unsigned ki;
      int unsigned b;
      int unsigned r;
      int unsigned c;
      gi = 32'(g);
      ki = 32'(k);
      if (gi < 9) begin
         r = gi;
         c = ki;
      end else if (gi < 18) begin
         r = ki;
         c = gi - 9;
      end else begin
         b = gi - 18;
         r = (b / 3) * 3 + ki / 3;
         c = (b % 3) * 3 + ki % 3;
      end
      return 7'(r * 9 + c);
   endfunction

endpackage

// File: rtl/sudoku_group_checker.sv
// Combinational check that nine digits hold exactly 1..9 once each. Only present when
// GAME_BOARD_AUTOCHECK_EN is defined.
`ifdef GAME_BOARD_AUTOCHECK_EN
module sudoku_group_checker
   import game_pkg::*;
(
   input  logic [8:0][DIGIT_W-1:0] digits,
   output logic                    ok
);

   logic [8:0] mask;

   always_comb begin
      mask = '0;
      for (int k = 0; k < 9; k++) begin
         if (digits[k] >= 4'd1 && digits[k] <= 4'd9) begin
            mask[digits[k] - 4'd1] = 1'b1;
         end
      end
   end

   assign ok = (mask == 9'h1FF);

endmodule
`endif

// File: rtl/game_board_ctrl.sv
// Sudoku board owner: loads a puzzle from ROM, applies handshaked digit writes and, when
// GAME_BOARD_AUTOCHECK_EN is defined, scans all 27 groups after each write to raise solved.
module game_board_ctrl
   import game_pkg::*;
#(
   parameter int unsigned PUZZLE_CNT = 4,
   parameter int unsigned ROM_AW     = 9
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          load_start,
   input  logic [$clog2(PUZZLE_CNT)-1:0] puzzle_sel,
   output logic [ROM_AW-1:0]             rom_addr,
   input  logic [4:0]                    rom_data,
   input  logic                          wr_valid,
   output logic                          wr_ready,
   input  logic [3:0]                    wr_row,
   input  logic [3:0]                    wr_col,
   input  logic [DIGIT_W-1:0]            wr_digit,
   output logic                          wr_reject,
   output logic [CELLS*DIGIT_W-1:0]      board,
   output logic [CELLS-1:0]              board_blank,
   output logic                          busy,
   output logic                          solved
);

   game_state_e              state_q, state_d;
   logic [6:0]               cnt_q, cnt_d;
   logic [ROM_AW-1:0]        addr_q, addr_d;
   logic [CELLS*DIGIT_W-1:0] board_q, board_d;
   logic [CELLS-1:0]         blank_q, blank_d;
   logic                     reject_q, reject_d;
   logic                     solved_q, solved_d;

   logic [ROM_AW-1:0] base_addr;
   logic [6:0]        ld_idx;
   logic [6:0]        wr_idx;
   logic              wr_fire;
   logic              wr_in_range;
   logic              wr_bad;

   assign base_addr   = ROM_AW'(32'(puzzle_sel) * 32'd81);
   // ROM data lags the address by one cycle, so the captured cell trails the counter.
   assign ld_idx      = cnt_q - 7'd1;
   assign wr_idx      = cell_idx(wr_row, wr_col);
   assign wr_fire     = wr_valid & wr_ready;
   assign wr_in_range = (wr_row <= 4'd8) && (wr_col <= 4'd8);
   assign wr_bad      = !wr_in_range || (wr_digit > 4'd9) || !blank_q[wr_idx] || solved_q;

`ifdef GAME_BOARD_AUTOCHECK_EN
   logic [4:0]                scan_q, scan_d;
   logic                      acc_q, acc_d;
   logic                      group_ok;
   logic [8:0][DIGIT_W-1:0]   grp_digits;

   always_comb begin
      for (int k = 0; k < 9; k++) begin
         grp_digits[k] = board_q[int'(group_cell(scan_q, 4'(k))) * DIGIT_W +: DIGIT_W];
      end
   end

   sudoku_group_checker u_checker (
      .digits (grp_digits),
      .ok     (group_ok)
   );
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      board_d  = board_q;
      blank_d  = blank_q;
      reject_d = 1'b0;
      solved_d = solved_q;
`ifdef GAME_BOARD_AUTOCHECK_EN
      scan_d   = scan_q;
      acc_d    = acc_q;
`endif
      // A load request outside LOAD always wins, aborting a scan or dropping a write.
      if (load_start && state_q != StLoad) begin
         state_d  = StLoad;
         cnt_d    = '0;
         addr_d   = base_addr;
         solved_d = 1'b0;
      end else begin
         unique case (state_q)
            StLoad: begin
               if (cnt_q != 7'd0) begin
                  board_d[int'(ld_idx) * DIGIT_W +: DIGIT_W] = rom_data[4] ? rom_data[3:0] : '0;
                  blank_d[ld_idx] = ~rom_data[4];
               end
               if (cnt_q == 7'(CELLS)) begin
                  state_d = StPlay;
               end else begin
                  cnt_d = cnt_q + 7'd1;
                  if (cnt_q < 7'(CELLS - 1)) begin
                     addr_d = addr_q + ROM_AW'(1);
                  end
               end
            end
            StPlay: begin
               if (wr_fire) begin
                  if (wr_bad) begin
                     reject_d = 1'b1;
                  end else begin
                     board_d[int'(wr_idx) * DIGIT_W +: DIGIT_W] = wr_digit;
`ifdef GAME_BOARD_AUTOCHECK_EN
                     state_d = StCheck;
                     scan_d  = '0;
                     acc_d   = 1'b1;
`endif
                  end
               end
            end
`ifdef GAME_BOARD_AUTOCHECK_EN
            StCheck: begin
               acc_d = acc_q & group_ok;
               if (scan_q == 5'(GROUPS - 1)) begin
                  solved_d = acc_q & group_ok;
                  state_d  = StPlay;
               end else begin
                  scan_d = scan_q + 5'd1;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         addr_q   <= '0;
         board_q  <= '0;
         blank_q  <= '1;
         reject_q <= 1'b0;
         solved_q <= 1'b0;
`ifdef GAME_BOARD_AUTOCHECK_EN
         scan_q   <= '0;
         acc_q    <= 1'b1;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         board_q  <= board_d;
         blank_q  <= blank_d;
         reject_q <= reject_d;
         solved_q <= solved_d;
`ifdef GAME_BOARD_AUTOCHECK_EN
         scan_q   <= scan_d;
         acc_q    <= acc_d;
`endif
      end
   end

   assign wr_ready    = (state_q == StPlay);
   assign busy        = (state_q == StLoad) || (state_q == StCheck);
   assign rom_addr    = addr_q;
   assign board       = board_q;
   assign board_blank = blank_q;
   assign wr_reject   = reject_q;
   assign solved      = solved_q;

endmodule

// File: tb/tb_game_board_ctrl.sv
// Self-checking bench for game_board_ctrl: ROM model, table of write vectors and directed
// load/check/abort/reset sequences.
`timescale 1ns/1ps
module tb_game_board_ctrl;

`ifdef GAME_BOARD_AUTOCHECK_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         load_start;
   logic [1:0]   puzzle_sel;
   logic [8:0]   rom_addr;
   logic [4:0]   rom_data;
   logic         wr_valid;
   logic         wr_ready;
   logic [3:0]   wr_row;
   logic [3:0]   wr_col;
   logic [3:0]   wr_digit;
   logic         wr_reject;
   logic [323:0] board;
   logic [80:0]  board_blank;
   logic         busy;
   logic         solved;

   always #5 clk = ~clk;

   game_board_ctrl #(
      .PUZZLE_CNT (4),
      .ROM_AW     (9)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .load_start  (load_start),
      .puzzle_sel  (puzzle_sel),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_row      (wr_row),
      .wr_col      (wr_col),
      .wr_digit    (wr_digit),
      .wr_reject   (wr_reject),
      .board       (board),
      .board_blank (board_blank),
      .busy        (busy),
      .solved      (solved)
   );

   logic [4:0] rom [0:511];
   always @(posedge clk) rom_data <= rom[rom_addr];

   logic [323:0] exp_board;
   logic [80:0]  exp_blank;
   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [3:0] row;
      logic [3:0] col;
      logic [3:0] digit;
      logic       rej;
   } wr_vec_t;

   wr_vec_t vecs [10];

   task automatic check(input string name, input logic [323:0] act, input logic [323:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] sol(input int r, input int c);
      return 4'(((r * 3 + r / 3 + c) % 9) + 1);
   endfunction

   task automatic model_load(input int p);
      logic [4:0] d;
      for (int i = 0; i < 81; i++) begin
         d = rom[p * 81 + i];
         exp_board[i*4 +: 4] = d[4] ? d[3:0] : 4'd0;
         exp_blank[i] = ~d[4];
      end
   endtask

   task automatic wait_not_busy(output int cyc);
      cyc = 0;
      while (busy === 1'b1 && cyc < 200) begin
         cyc++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_load(input int p);
      int cyc;
      @(negedge clk);
      load_start = 1'b1;
      puzzle_sel = 2'(p);
      @(posedge clk);
      #1;
      load_start = 1'b0;
      check("load_solved_clr", solved, 0);
      cyc = 0;
      while (busy === 1'b1 && cyc < 200) begin
         cyc++;
         if (cyc == 1) check("load_addr_first", rom_addr, 9'(p * 81));
         if (cyc == 81) check("load_addr_last", rom_addr, 9'(p * 81 + 80));
         @(posedge clk);
         #1;
      end
      model_load(p);
      check("load_busy_cycles", cyc, 82);
      check("load_ready", wr_ready, 1);
      check("load_board", board, exp_board);
      check("load_blank", board_blank, exp_blank);
   endtask

   task automatic do_write(input logic [3:0] row, input logic [3:0] col, input logic [3:0] digit,
                           input logic exp_rej, output int busy_cyc);
      @(negedge clk);
      check("wr_ready_before", wr_ready, 1);
      wr_valid = 1'b1;
      wr_row   = row;
      wr_col   = col;
      wr_digit = digit;
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
      check("wr_reject", wr_reject, exp_rej);
      if (!exp_rej) exp_board[(int'(row) * 9 + int'(col)) * 4 +: 4] = digit;
      check("wr_board", board, exp_board);
      check("wr_blank", board_blank, exp_blank);
      busy_cyc = 0;
      while (busy === 1'b1 && busy_cyc < 60) begin
         busy_cyc++;
         @(posedge clk);
         #1;
      end
      if (busy_cyc == 0) begin
         @(posedge clk);
         #1;
      end
      check("wr_reject_one_cycle", wr_reject, 0);
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      int bc;
      for (int p = 0; p < 4; p++) begin
         for (int i = 0; i < 81; i++) begin
            case (p)
               0: rom[p*81+i] = (i == 80) ? {1'b0, 4'd3} : {1'b1, sol(i / 9, i % 9)};
               1: rom[p*81+i] = (i == 0) ? {1'b1, 4'd5} :
                                (i % 2 == 0) ? {1'b1, sol(i / 9, i % 9)} : {1'b0, 4'd7};
               default: rom[p*81+i] = {1'b0, 4'd9};
            endcase
         end
      end
      for (int i = 324; i < 512; i++) rom[i] = 5'd0;

      vecs[0] = '{4'd0,  4'd0,  4'd3,  1'b1};
      vecs[1] = '{4'd9,  4'd0,  4'd1,  1'b1};
      vecs[2] = '{4'd0,  4'd9,  4'd1,  1'b1};
      vecs[3] = '{4'd0,  4'd1,  4'd10, 1'b1};
      vecs[4] = '{4'd0,  4'd1,  4'd4,  1'b0};
      vecs[5] = '{4'd0,  4'd1,  4'd0,  1'b0};
      vecs[6] = '{4'd8,  4'd7,  4'd9,  1'b0};
      vecs[7] = '{4'd8,  4'd8,  4'd1,  1'b1};
      vecs[8] = '{4'd15, 4'd15, 4'd15, 1'b1};
      vecs[9] = '{4'd4,  4'd5,  4'd2,  1'b0};

      rst = 1'b1;
      load_start = 1'b0;
      puzzle_sel = 2'd0;
      wr_valid = 1'b0;
      wr_row = 4'd0;
      wr_col = 4'd0;
      wr_digit = 4'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_board", board, 0);
      check("rst_blank", board_blank, {81{1'b1}});
      check("rst_rom_addr", rom_addr, 0);
      check("rst_wr_ready", wr_ready, 0);
      check("rst_wr_reject", wr_reject, 0);
      check("rst_busy", busy, 0);
      check("rst_solved", solved, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("idle_wr_ready", wr_ready, 0);

      // Puzzle 1: given/blank capture.
      do_load(1);
      check("p1_cell0", board[3:0], 4'd5);
      check("p1_cell1", board[7:4], 4'd0);
      check("p1_blank01", board_blank[1:0], 2'b10);

      for (int v = 0; v < 10; v++) begin
         do_write(vecs[v].row, vecs[v].col, vecs[v].digit, vecs[v].rej, bc);
         check("vec_busy_cycles", bc, (AUTO && !vecs[v].rej) ? 27 : 0);
      end
      check("vec_solved", solved, 0);

      // Load coincident with a legal write: write dropped, no reject.
      @(negedge clk);
      load_start = 1'b1;
      puzzle_sel = 2'd1;
      wr_valid = 1'b1;
      wr_row = 4'd0;
      wr_col = 4'd3;
      wr_digit = 4'd6;
      @(posedge clk);
      #1;
      load_start = 1'b0;
      wr_valid = 1'b0;
      check("coinc_reject", wr_reject, 0);
      check("coinc_busy", busy, 1);
      wait_not_busy(bc);
      model_load(1);
      check("coinc_load_cycles", bc, 82);
      check("coinc_board", board, exp_board);

`ifndef GAME_BOARD_AUTOCHECK_EN
      // Back-to-back writes on consecutive edges.
      @(negedge clk);
      wr_valid = 1'b1;
      wr_row = 4'd0;
      wr_col = 4'd3;
      wr_digit = 4'd7;
      @(posedge clk);
      #1;
      exp_board[3*4 +: 4] = 4'd7;
      check("b2b_first_board", board, exp_board);
      check("b2b_ready", wr_ready, 1);
      wr_row = 4'd1;
      wr_col = 4'd0;
      wr_digit = 4'd2;
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
      exp_board[9*4 +: 4] = 4'd2;
      check("b2b_second_board", board, exp_board);
      check("b2b_reject", wr_reject, 0);

      do_load(0);
      do_write(4'd8, 4'd8, 4'd8, 1'b0, bc);
      check("noauto_busy", bc, 0);
      check("noauto_solved", solved, 0);
`else
      do_load(0);
      do_write(4'd8, 4'd8, 4'd1, 1'b0, bc);
      check("wrong_busy_cycles", bc, 27);
      check("wrong_solved", solved, 0);

      do_load(0);
      // Abort a scan in its tenth cycle.
      @(negedge clk);
      wr_valid = 1'b1;
      wr_row = 4'd8;
      wr_col = 4'd8;
      wr_digit = 4'd8;
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
      check("abort_busy_in_check", busy, 1);
      repeat (9) @(posedge clk);
      @(negedge clk);
      load_start = 1'b1;
      puzzle_sel = 2'd0;
      @(posedge clk);
      #1;
      load_start = 1'b0;
      check("abort_rom_addr", rom_addr, 0);
      check("abort_solved", solved, 0);
      check("abort_ready", wr_ready, 0);
      wait_not_busy(bc);
      model_load(0);
      check("abort_load_cycles", bc, 82);
      check("abort_board", board, exp_board);
      check("abort_solved_after", solved, 0);

      do_write(4'd8, 4'd8, 4'd8, 1'b0, bc);
      check("solve_busy_cycles", bc, 27);
      check("solve_solved", solved, 1);
      do_write(4'd8, 4'd8, 4'd2, 1'b1, bc);
      check("post_solve_busy", bc, 0);
      check("post_solve_solved", solved, 1);
`endif

      // Reset in the middle of a load.
      @(negedge clk);
      load_start = 1'b1;
      puzzle_sel = 2'd2;
      @(posedge clk);
      #1;
      load_start = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("rstld_board", board, 0);
      check("rstld_blank", board_blank, {81{1'b1}});
      check("rstld_busy", busy, 0);
      check("rstld_rom_addr", rom_addr, 0);
      check("rstld_solved", solved, 0);
      repeat (5) @(posedge clk);
      #1;
      check("rstld_idle_busy", busy, 0);
      check("rstld_idle_ready", wr_ready, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
